// File: rtl/interface_name_pkg_hdl.sv
// Shared types and helpers for the interface_name stream arbiter.
// Round-robin search and bus slicing used by the top level.
package interface_name_pkg_hdl;

   typedef enum logic {IDLE, LOCKED} arb_state_t;

   localparam int MAX_CH  = 16;
   localparam int MAX_W   = 64;
   localparam int MAX_BUS = MAX_CH * MAX_W;

   // First requester at or above ptr, wrapping at n-1 -> 0.
   function automatic logic [3:0] rr_next(
      input logic [3:0]        ptr,
      input logic [MAX_CH-1:0] req,
      input int                n
   );
      logic [3:0] g;
      logic       hit;
      int         idx;
      g   = ptr;
      hit = 1'b0;
      for (int i = 0; i < MAX_CH; i++) begin
         if (i < n) begin
            idx = int'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if (!hit && req[idx]) begin
               g   = 4'(idx);
               hit = 1'b1;
            end
         end
      end
      return g;
   endfunction

   function automatic logic [MAX_W-1:0] ch_slice(
      input logic [MAX_BUS-1:0] bus,
      input int                 c,
      input int                 w
   );
      logic [MAX_BUS-1:0] sh;
      sh = bus >> (c * w);
      return sh[MAX_W-1:0];
   endfunction

endpackage

// File: rtl/interface_name_chan_fifo.sv
// Per-channel synchronous FIFO, pointers carry a wrap bit
// so full and empty fall out of a plain compare.
module interface_name_chan_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wp;
   logic [AW:0]  rp;

   assign full  = (wp[AW] != rp[AW]) &&
                  (wp[AW-1:0] == rp[AW-1:0]);
   assign empty = (wp == rp);
   assign rdata = mem[rp[AW-1:0]];

   always_ff @(posedge clock) begin
      if (push && !full) mem[wp[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wp <= '0;
         rp <= '0;
      end else begin
         if (push && !full) wp <= wp + 1'b1;
         if (pop && !empty) rp <= rp + 1'b1;
      end
   end

endmodule

// File: rtl/interface_name_stream_arbiter.sv
// N-channel buffered stream merger: round-robin grant, optional
// packet lock, registered output and sticky handshake checks.
module interface_name_stream_arbiter
   import interface_name_pkg_hdl::*;
#(
   parameter int NUM_CH      = 4,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 4,
   parameter int PACKET_MODE = 1,
   parameter int CH_W        = $clog2(NUM_CH)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        in_valid,
   output logic [NUM_CH-1:0]        in_ready,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic [NUM_CH-1:0]        in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_last,
   output logic [CH_W-1:0]          out_ch,
   input  logic                     err_clr,
   output logic [NUM_CH-1:0]        proto_err
);

   logic [MAX_BUS-1:0] bus_pad;
   logic [NUM_CH-1:0]  full, empty, push, pop;
   logic [DATA_W:0]    rdata [NUM_CH];
   logic [DATA_W-1:0]  chd   [NUM_CH];

   arb_state_t      state, state_nxt;
   logic [CH_W-1:0] lock_ch, lock_nxt;
   logic [CH_W-1:0] ptr, ptr_nxt;
   logic [CH_W-1:0] gnt;
   logic            load;
   logic [DATA_W:0] beat;

   logic [NUM_CH-1:0] armed, cap_last, err;
   logic [DATA_W-1:0] cap_data [NUM_CH];

   assign bus_pad  = MAX_BUS'(in_data);
   assign in_ready = ~full & {NUM_CH{reset}};

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign chd[c]  = DATA_W'(ch_slice(bus_pad, c, DATA_W));
      assign push[c] = in_valid[c] & in_ready[c];

      interface_name_chan_fifo #(
         .W     (DATA_W + 1),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clock (clock),
         .reset (reset),
         .push  (push[c]),
         .wdata ({in_last[c], chd[c]}),
         .pop   (pop[c]),
         .rdata (rdata[c]),
         .full  (full[c]),
         .empty (empty[c])
      );
   end

   always_comb begin
      state_nxt = state;
      lock_nxt  = lock_ch;
      ptr_nxt   = ptr;
      pop       = '0;
      if (state == LOCKED) gnt = lock_ch;
      else gnt = CH_W'(rr_next(4'(ptr), MAX_CH'(~empty), NUM_CH));
      load = (!out_valid || out_ready) && !empty[gnt];
      beat = rdata[gnt];
      if (load) begin
         pop[gnt] = 1'b1;
         if (beat[DATA_W] || PACKET_MODE == 0)
            ptr_nxt = (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
         if (PACKET_MODE != 0) begin
            state_nxt = beat[DATA_W] ? IDLE : LOCKED;
            lock_nxt  = gnt;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         lock_ch   <= '0;
         ptr       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_ch    <= '0;
      end else begin
         state   <= state_nxt;
         lock_ch <= lock_nxt;
         ptr     <= ptr_nxt;
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= beat[DATA_W-1:0];
            out_last  <= beat[DATA_W];
            out_ch    <= gnt;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // A stalled beat must be repeated unchanged on the next cycle.
   always_comb begin
      err = '0;
      for (int c = 0; c < NUM_CH; c++)
         err[c] = armed[c] & (!in_valid[c] ||
                  chd[c] != cap_data[c] ||
                  in_last[c] != cap_last[c]);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         armed     <= '0;
         cap_last  <= '0;
         proto_err <= '0;
         for (int c = 0; c < NUM_CH; c++) cap_data[c] <= '0;
      end else begin
         armed     <= in_valid & ~in_ready;
         cap_last  <= in_last;
         proto_err <= (proto_err & ~{NUM_CH{err_clr}}) | err;
         for (int c = 0; c < NUM_CH; c++) cap_data[c] <= chd[c];
      end
   end

endmodule

// File: tb/tb_interface_name_stream_arbiter.sv
// Bench for interface_name_stream_arbiter: directed sequences,
// a vector table and random traffic against a queue model.
module tb_interface_name_stream_arbiter;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int D  = 4;
   localparam int PM = 1;

   logic           clock = 1'b0;
   logic           reset = 1'b0;
   logic [N-1:0]   in_valid = '0;
   logic [N-1:0]   in_ready;
   logic [N*W-1:0] in_data = '0;
   logic [N-1:0]   in_last = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [W-1:0]   out_data;
   logic           out_last;
   logic [1:0]     out_ch;
   logic           err_clr = 1'b0;
   logic [N-1:0]   proto_err;

   logic [N-1:0]   in_ready0;
   logic           out_valid0;
   logic [W-1:0]   out_data0;
   logic           out_last0;
   logic [1:0]     out_ch0;
   logic [N-1:0]   proto_err0;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   interface_name_stream_arbiter #(
      .NUM_CH(N), .DATA_W(W), .DEPTH(D), .PACKET_MODE(1)
   ) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last),
      .out_ch(out_ch), .err_clr(err_clr),
      .proto_err(proto_err)
   );

   interface_name_stream_arbiter #(
      .NUM_CH(N), .DATA_W(W), .DEPTH(D), .PACKET_MODE(0)
   ) dut0 (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(out_data0), .out_last(out_last0),
      .out_ch(out_ch0), .err_clr(err_clr),
      .proto_err(proto_err0)
   );

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   // Reference model: FIFO queues plus the arbitration rules.
   logic [32:0]  mq [N][$];
   logic [34:0]  obs[$];
   logic [34:0]  obs0[$];
   logic         mv = 1'b0, ml = 1'b0, locked = 1'b0;
   logic [31:0]  md = '0;
   int           mc = 0, lch = 0, mptr = 0, g;
   logic [N-1:0] marmed = '0, mclast = '0, merr = '0;
   logic [N-1:0] rdy, e;
   logic [31:0]  mcdata [N];
   logic [32:0]  mb;

   always @(negedge clock) begin
      if (!reset) begin
         chk("rst_out_valid", 64'(out_valid), 64'(0));
         chk("rst_in_ready", 64'(in_ready), 64'(0));
         chk("rst_proto_err", 64'(proto_err), 64'(0));
         for (int c = 0; c < N; c++) mq[c].delete();
         mv = 0; ml = 0; md = '0; mc = 0;
         locked = 0; lch = 0; mptr = 0;
         marmed = '0; mclast = '0; merr = '0;
      end else begin
         if (out_valid && out_ready)
            obs.push_back({out_ch, out_last, out_data});
         if (out_valid0 && out_ready)
            obs0.push_back({out_ch0, out_last0, out_data0});
         chk("out_valid", 64'(out_valid), 64'(mv));
         if (mv) begin
            chk("out_data", 64'(out_data), 64'(md));
            chk("out_last", 64'(out_last), 64'(ml));
            chk("out_ch", 64'(out_ch), 64'(mc));
         end
         for (int c = 0; c < N; c++) rdy[c] = mq[c].size() < D;
         chk("in_ready", 64'(in_ready), 64'(rdy));
         chk("proto_err", 64'(proto_err), 64'(merr));
         g = -1;
         if (locked) begin
            if (mq[lch].size() > 0) g = lch;
         end else begin
            for (int i = 0; i < N; i++)
               if (g < 0 && mq[(mptr + i) % N].size() > 0)
                  g = (mptr + i) % N;
         end
         if ((!mv || out_ready) && g >= 0) begin
            mb = mq[g].pop_front();
            mv = 1; md = mb[31:0]; ml = mb[32]; mc = g;
            if (PM != 0) begin
               if (ml) begin
                  locked = 0;
                  mptr = (g + 1) % N;
               end else begin
                  locked = 1;
                  lch = g;
               end
            end else begin
               mptr = (g + 1) % N;
            end
         end else if (out_ready) begin
            mv = 0;
         end
         for (int c = 0; c < N; c++) begin
            if (in_valid[c] && rdy[c])
               mq[c].push_back({in_last[c], in_data[c*W +: W]});
            e[c] = marmed[c] && (!in_valid[c] ||
                   in_data[c*W +: W] != mcdata[c] ||
                   in_last[c] != mclast[c]);
            mcdata[c] = in_data[c*W +: W];
         end
         merr   = (merr & ~{N{err_clr}}) | e;
         marmed = in_valid & ~rdy;
         mclast = in_last;
      end
   end

   typedef struct {
      logic        rdy;
      logic        v;
      logic [1:0]  ch;
      logic [31:0] data;
   } vec_t;

   vec_t tv [10];
   int   n1;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      in_valid = '0; in_last = '0; in_data = '0;
      out_ready = 1'b0; err_clr = 1'b0;
      step(); step();
      reset = 1'b1;
      obs.delete(); obs0.delete();
      step();
   endtask

   task automatic put(input int c, input logic [31:0] d,
                      input logic l);
      in_valid[c] = 1'b1;
      in_data[c*W +: W] = d;
      in_last[c] = l;
   endtask

   initial begin
      tv[0] = '{1'b0, 1'b1, 2'd0, 32'h000};
      tv[1] = '{1'b1, 1'b1, 2'd0, 32'h000};
      tv[2] = '{1'b1, 1'b1, 2'd1, 32'h100};
      tv[3] = '{1'b1, 1'b1, 2'd2, 32'h200};
      tv[4] = '{1'b1, 1'b1, 2'd3, 32'h300};
      tv[5] = '{1'b1, 1'b1, 2'd0, 32'h001};
      tv[6] = '{1'b1, 1'b1, 2'd1, 32'h101};
      tv[7] = '{1'b1, 1'b1, 2'd2, 32'h201};
      tv[8] = '{1'b1, 1'b1, 2'd3, 32'h301};
      tv[9] = '{1'b1, 1'b0, 2'd0, 32'h000};

      // single beat latency
      do_reset();
      chk("t0_in_ready", 64'(in_ready), 64'hF);
      chk("t0_out_valid", 64'(out_valid), 64'(0));
      out_ready = 1'b1;
      put(2, 32'hA5, 1'b1);
      step();
      in_valid = '0;
      chk("t1_e0_valid", 64'(out_valid), 64'(0));
      step();
      chk("t1_valid", 64'(out_valid), 64'(1));
      chk("t1_data", 64'(out_data), 64'hA5);
      chk("t1_ch", 64'(out_ch), 64'(2));
      chk("t1_last", 64'(out_last), 64'(1));
      step();
      chk("t1_drain", 64'(out_valid), 64'(0));

      // round-robin table, pointer wraps 3 -> 0
      do_reset();
      for (int b = 0; b < 2; b++) begin
         for (int c = 0; c < N; c++)
            put(c, 32'(32'h100 * c + b), 1'b1);
         step();
      end
      in_valid = '0;
      for (int i = 0; i < 10; i++) begin
         out_ready = tv[i].rdy;
         chk("t2_valid", 64'(out_valid), 64'(tv[i].v));
         if (tv[i].v) begin
            chk("t2_ch", 64'(out_ch), 64'(tv[i].ch));
            chk("t2_data", 64'(out_data), 64'(tv[i].data));
         end
         step();
      end

      // packet lock versus per-beat arbitration
      do_reset();
      put(0, 32'hC0, 1'b0);
      put(1, 32'hD0, 1'b1);
      step();
      in_valid = '0;
      put(0, 32'hC1, 1'b0);
      step();
      put(0, 32'hC2, 1'b1);
      step();
      in_valid = '0;
      out_ready = 1'b1;
      repeat (6) step();
      chk("t3_cnt", 64'(obs.size()), 64'(4));
      chk("t3_cnt0", 64'(obs0.size()), 64'(4));
      for (int i = 0; i < 4; i++) begin
         chk("t3_pm1_ch", 64'(obs[i][34:33]),
             64'((i == 3) ? 1 : 0));
         chk("t3_pm0_ch", 64'(obs0[i][34:33]),
             64'((i == 1) ? 1 : 0));
      end
      chk("t3_pm1_d2", 64'(obs[2][31:0]), 64'hC2);

      // fill ch1 behind a stalled ch0 beat
      do_reset();
      put(0, 32'hE0, 1'b1);
      step();
      in_valid = '0;
      step();
      for (int k = 0; k < 4; k++) begin
         chk("t4_rdy", 64'(in_ready[1]), 64'(1));
         put(1, 32'(32'h10 + k), 1'b1);
         step();
      end
      chk("t4_full", 64'(in_ready[1]), 64'(0));
      put(1, 32'h99, 1'b1);
      step();
      chk("t4_still_full", 64'(in_ready[1]), 64'(0));
      in_valid = '0;
      out_ready = 1'b1;
      repeat (8) step();
      n1 = 0;
      foreach (obs[i]) begin
         if (obs[i][34:33] == 2'd1) begin
            chk("t4_order", 64'(obs[i][31:0]), 64'(32'h10 + n1));
            n1++;
         end
      end
      chk("t4_ch1_cnt", 64'(n1), 64'(4));

      // sticky protocol flag on ch3
      do_reset();
      for (int k = 0; k < 5; k++) begin
         put(3, 32'(32'h30 + k), 1'b0);
         step();
      end
      chk("t5_full", 64'(in_ready[3]), 64'(0));
      put(3, 32'h1, 1'b0);
      step();
      chk("t5_armed", 64'(proto_err[3]), 64'(0));
      put(3, 32'h2, 1'b0);
      step();
      chk("t5_set", 64'(proto_err[3]), 64'(1));
      in_valid = '0;
      step(); step();
      chk("t5_hold", 64'(proto_err[3]), 64'(1));
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("t5_clr", 64'(proto_err[3]), 64'(0));
      put(3, 32'h5, 1'b0);
      step();
      in_valid = '0;
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("t5_set_wins", 64'(proto_err[3]), 64'(1));

      // reset mid-packet with three queues loaded
      do_reset();
      put(0, 32'h60, 1'b0);
      put(1, 32'h61, 1'b1);
      put(2, 32'h62, 1'b1);
      step();
      in_valid = '0;
      put(0, 32'h63, 1'b0);
      step();
      in_valid = '0;
      step();
      chk("t6_pre_valid", 64'(out_valid), 64'(1));
      reset = 1'b0;
      #1;
      chk("t6_rst_valid", 64'(out_valid), 64'(0));
      chk("t6_rst_ready", 64'(in_ready), 64'(0));
      step();
      reset = 1'b1;
      #1;
      chk("t6_rel_ready", 64'(in_ready), 64'hF);
      step(); step();
      chk("t6_idle", 64'(out_valid), 64'(0));
      put(1, 32'h71, 1'b1);
      put(0, 32'h70, 1'b1);
      step();
      in_valid = '0;
      step();
      chk("t6_first", 64'(out_ch), 64'(0));
      out_ready = 1'b1;
      step();
      chk("t6_second", 64'(out_ch), 64'(1));

      // random traffic, model checks every cycle
      do_reset();
      for (int t = 0; t < 3000; t++) begin
         for (int c = 0; c < N; c++) begin
            if (!(in_valid[c] && !in_ready[c] &&
                  $urandom_range(0, 15) != 0)) begin
               in_valid[c] = 1'($urandom_range(0, 1));
               in_data[c*W +: W] = $urandom;
               in_last[c] = ($urandom_range(0, 3) == 0);
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         err_clr = ($urandom_range(0, 19) == 0);
         step();
      end
      in_valid = '0;
      err_clr = 1'b0;
      out_ready = 1'b1;
      repeat (40) step();
      chk("rand_drained", 64'(out_valid), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
